// File: rtl/fp_mantissa_sub_norm.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mantissa_sub_norm
//  Description : Iterative subtract-and-normalise unit for the effective-
//                subtraction path of the 32-bit floating-point datapath.
//                Takes two pre-aligned mantissas that share one exponent,
//                forms |a - b| and its sign, then left-normalises the
//                magnitude while decrementing the exponent. The exponent
//                never goes below zero; if it runs out before the MSB is
//                set, the result is flagged as denormal.
//
//  Build option: FAST_NORM_EN
//                Undefined : one bit of left shift per NORM cycle.
//                Defined   : each NORM cycle shifts by min(lz4, exp), where
//                            lz4 is the leading-zero count of the top four
//                            magnitude bits (4 if all zero). Results are the
//                            same either way; only latency changes.
//
//  Ports       : clk        - single clock
//                rst_n      - synchronous active-low reset
//                in_valid   - operands valid
//                in_ready   - unit idle, can accept operands
//                a_man      - minuend mantissa (aligned), MAN_W bits
//                b_man      - subtrahend mantissa (aligned), MAN_W bits
//                exp_in     - common exponent, EXP_W bits
//                out_valid  - result valid (held until out_ready)
//                out_ready  - downstream accepts result
//                res_man    - normalised magnitude, MAN_W bits
//                res_exp    - adjusted exponent, EXP_W bits
//                res_sign   - 1 when b_man > a_man
//                res_zero   - difference was zero
//                res_denorm - exponent exhausted before normalisation
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mantissa_sub_norm #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] a_man,
    input  logic [MAN_W-1:0] b_man,
    input  logic [EXP_W-1:0] exp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] res_man,
    output logic [EXP_W-1:0] res_exp,
    output logic             res_sign,
    output logic             res_zero,
    output logic             res_denorm
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [MAN_W-1:0] r_a, w_a_nxt;
    logic [MAN_W-1:0] r_b, w_b_nxt;
    logic [MAN_W-1:0] r_mag, w_mag_nxt;
    logic [EXP_W-1:0] r_exp, w_exp_nxt;
    logic             r_sign, w_sign_nxt;
    logic             r_zero, w_zero_nxt;
    logic             r_denorm, w_denorm_nxt;
    logic             r_out_valid, w_out_valid_nxt;

    // ------------------------------------------------------------------------
    // Subtraction datapath
    // a + ~b + 1 in MAN_W+1 bits: the carry-out is set exactly when a >= b,
    // in which case the low MAN_W bits are already the magnitude.
    // ------------------------------------------------------------------------
    logic [MAN_W:0]   w_diff;
    logic [MAN_W-1:0] w_rev_diff;
    logic             w_carry;

    assign w_diff     = {1'b0, r_a} + {1'b0, ~r_b} + {{MAN_W{1'b0}}, 1'b1};
    assign w_carry    = w_diff[MAN_W];
    assign w_rev_diff = r_b - r_a;

    // ------------------------------------------------------------------------
    // Normalisation shift amount
    // The shift step is only taken when mag != 0, mag MSB == 0 and exp != 0,
    // so the amount is always at least 1 and never exceeds the exponent.
    // ------------------------------------------------------------------------
    logic [2:0]       w_shamt;
    logic [EXP_W-1:0] w_shamt_ext;
    logic [MAN_W-1:0] w_shift_mag;

`ifdef FAST_NORM_EN
    logic [2:0] w_lz4;
    logic       w_exp_lt_lz4;

    always_comb begin
        w_lz4 = 3'd4;
        casez (r_mag[MAN_W-1 -: 4])
            4'b1???: w_lz4 = 3'd0;
            4'b01??: w_lz4 = 3'd1;
            4'b001?: w_lz4 = 3'd2;
            4'b0001: w_lz4 = 3'd3;
            default: w_lz4 = 3'd4;
        endcase
    end

    // Clamp to the remaining exponent so it cannot wrap below zero.
    assign w_exp_lt_lz4 = (r_exp < {{(EXP_W-3){1'b0}}, w_lz4});
    assign w_shamt      = w_exp_lt_lz4 ? r_exp[2:0] : w_lz4;
`else
    assign w_shamt = 3'd1;
`endif

    assign w_shamt_ext = {{(EXP_W-3){1'b0}}, w_shamt};
    assign w_shift_mag = r_mag << w_shamt;

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_mag_nxt       = r_mag;
        w_exp_nxt       = r_exp;
        w_sign_nxt      = r_sign;
        w_zero_nxt      = r_zero;
        w_denorm_nxt    = r_denorm;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_a_nxt      = a_man;
                    w_b_nxt      = b_man;
                    w_exp_nxt    = exp_in;
                    w_sign_nxt   = 1'b0;
                    w_zero_nxt   = 1'b0;
                    w_denorm_nxt = 1'b0;
                    w_state_nxt  = ST_SUB;
                end
            end

            ST_SUB: begin
                if (w_carry) begin
                    w_mag_nxt  = w_diff[MAN_W-1:0];
                    w_sign_nxt = 1'b0;
                end else begin
                    w_mag_nxt  = w_rev_diff;
                    w_sign_nxt = 1'b1;
                end
                w_state_nxt = ST_NORM;
            end

            ST_NORM: begin
                if (r_mag == '0) begin
                    // Exact cancellation: canonical +0 with zero exponent.
                    w_zero_nxt  = 1'b1;
                    w_exp_nxt   = '0;
                    w_sign_nxt  = 1'b0;
                    w_state_nxt = ST_DONE;
                end else if (r_mag[MAN_W-1]) begin
                    w_state_nxt = ST_DONE;
                end else if (r_exp == '0) begin
                    w_denorm_nxt = 1'b1;
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_mag_nxt = w_shift_mag;
                    w_exp_nxt = r_exp - w_shamt_ext;
                end
            end

            ST_DONE: begin
                // out_valid is registered, so it rises one cycle after DONE
                // is entered and falls on the same edge that returns to IDLE.
                if (!r_out_valid) begin
                    w_out_valid_nxt = 1'b1;
                end else if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_denorm    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_mag       <= w_mag_nxt;
            r_exp       <= w_exp_nxt;
            r_sign      <= w_sign_nxt;
            r_zero      <= w_zero_nxt;
            r_denorm    <= w_denorm_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // in_ready is gated by rst_n so it stays low for the whole reset period.
    // ------------------------------------------------------------------------
    assign in_ready   = rst_n && (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign res_man    = r_mag;
    assign res_exp    = r_exp;
    assign res_sign   = r_sign;
    assign res_zero   = r_zero;
    assign res_denorm = r_denorm;

endmodule
`default_nettype wire

// File: tb/tb_fp_mantissa_sub_norm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mantissa_sub_norm
//  Description : Self-checking bench for fp_mantissa_sub_norm. A driver
//                issues operands and pushes the reference result (and its
//                expected latency) into a scoreboard queue; an independent
//                monitor compares whatever the unit presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mantissa_sub_norm;

    localparam int MAN_W = 24;
    localparam int EXP_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;
    logic [EXP_W-1:0] exp_in;
    logic             out_valid;
    logic             out_ready;
    logic [MAN_W-1:0] res_man;
    logic [EXP_W-1:0] res_exp;
    logic             res_sign;
    logic             res_zero;
    logic             res_denorm;

    fp_mantissa_sub_norm #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_man      (a_man),
        .b_man      (b_man),
        .exp_in     (exp_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res_man    (res_man),
        .res_exp    (res_exp),
        .res_sign   (res_sign),
        .res_zero   (res_zero),
        .res_denorm (res_denorm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [MAN_W-1:0] man;
        logic [EXP_W-1:0] ex;
        bit               sign;
        bit               zero;
        bit               denorm;
        int               k;
        int               lat;
    } exp_t;

    exp_t q[$];

    // ------------------------------------------------------------------------
    // Reference model: |a-b| by plain integer arithmetic, then normalise
    // until the top bit is set or the exponent hits zero.
    // ------------------------------------------------------------------------
    function automatic exp_t model(input logic [MAN_W-1:0] a,
                                   input logic [MAN_W-1:0] b,
                                   input logic [EXP_W-1:0] e);
        exp_t r;
        int mag, ex, it, s, lz;
        r.sign = 0; r.zero = 0; r.denorm = 0; r.k = 0;
        if (int'(a) >= int'(b)) mag = int'(a) - int'(b);
        else begin mag = int'(b) - int'(a); r.sign = 1; end
        ex = int'(e);
        it = 0;
        if (mag == 0) begin
            r.zero = 1; r.sign = 0; ex = 0;
        end else begin
            for (int g = 0; g < 64; g++) begin
                if (mag >= (1 << (MAN_W-1))) break;
                if (ex == 0) begin r.denorm = 1; break; end
`ifdef FAST_NORM_EN
                lz = 4;
                for (int j = 0; j < 4; j++)
                    if (mag >= (1 << (MAN_W-1-j))) begin lz = j; break; end
                s = (lz < ex) ? lz : ex;
`else
                lz = 1;
                s = lz;
`endif
                mag = mag << s;
                ex  = ex - s;
                it++;
            end
        end
        r.man = mag[MAN_W-1:0];
        r.ex  = ex[EXP_W-1:0];
        r.lat = 3 + it;
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Downstream ready: random unless a test holds it low.
    // ------------------------------------------------------------------------
    bit force_hold = 0;
    always @(posedge clk) begin
        #1;
        if (!force_hold) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    bit               seen = 0;
    bit               prev_v = 0;
    bit               chk_idle = 0;
    logic [MAN_W+EXP_W+2:0] prev_res;

    always @(negedge clk) begin
        exp_t e;
        logic [MAN_W+EXP_W+2:0] cur;
        cur = {res_man, res_exp, res_sign, res_zero, res_denorm};
        if (!rst_n) begin
            seen = 0; prev_v = 0; chk_idle = 0;
        end else begin
            if (chk_idle) begin
                compared++;
                if (!(in_ready && !out_valid)) begin
                    mismatched++;
                    $display("FAIL post_handshake: in_ready=%0b out_valid=%0b, required in_ready=1 out_valid=0",
                             in_ready, out_valid);
                end
                chk_idle = 0;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_output: out_valid=1 man=%h exp=%h, required no output", res_man, res_exp);
                end else begin
                    e = q[0];
                    if (!seen) begin
                        compared++;
                        if (cyc - e.k != e.lat) begin
                            mismatched++;
                            $display("FAIL latency: got %0d cycles, required %0d", cyc - e.k, e.lat);
                        end
                        seen = 1;
                    end
                    if (prev_v) begin
                        compared++;
                        if (cur !== prev_res) begin
                            mismatched++;
                            $display("FAIL hold_stable: res=%h, required %h", cur, prev_res);
                        end
                    end
                    compared++;
                    if (in_ready !== 1'b0) begin
                        mismatched++;
                        $display("FAIL busy_ready: in_ready=%0b, required 0", in_ready);
                    end
                    if (out_ready) begin
                        compared++;
                        if (res_man !== e.man || res_exp !== e.ex || res_sign !== e.sign ||
                            res_zero !== e.zero || res_denorm !== e.denorm) begin
                            mismatched++;
                            $display("FAIL result: man=%h exp=%h s=%0b z=%0b d=%0b, required man=%h exp=%h s=%0b z=%0b d=%0b",
                                     res_man, res_exp, res_sign, res_zero, res_denorm,
                                     e.man, e.ex, e.sign, e.zero, e.denorm);
                        end
                        void'(q.pop_front());
                        seen = 0;
                        chk_idle = 1;
                    end
                end
            end
            prev_v   = out_valid && !out_ready;
            prev_res = cur;
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------------
    task automatic send(input logic [MAN_W-1:0] a, input logic [MAN_W-1:0] b,
                        input logic [EXP_W-1:0] e);
        exp_t r;
        bit   ok;
        @(posedge clk); #1;
        in_valid = 1; a_man = a; b_man = b; exp_in = e;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                r = model(a, b, e);
                r.k = cyc + 1;
                q.push_back(r);
                ok = 1;
            end
        end
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL accept_timeout: in_ready=%0b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (q.size() == 0) done = 1;
        end
        if (!done) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout: pending=%0d, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [MAN_W-1:0] a, b;
        logic [EXP_W-1:0] e;
        bit hit;

        rst_n = 0; in_valid = 0; a_man = '0; b_man = '0; exp_in = '0; out_ready = 0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_results", 64'({res_man, res_exp, res_sign, res_zero, res_denorm}), 64'd0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);

        // Directed cases.
        send(24'h400000, 24'hC00000, 8'h85); drain();
        send(24'hABCDEF, 24'hABCDEF, 8'h90); drain();
        send(24'h000003, 24'h000002, 8'h05); drain();

        // Case 1 with downstream stalled, plus ignored in_valid pulses.
        force_hold = 1; out_ready = 0;
        send(24'h800000, 24'h400000, 8'h80);
        hit = 0;
        for (int t = 0; t < 100 && !hit; t++) begin
            @(negedge clk);
            if (out_valid) hit = 1;
        end
        check("stall_valid_seen", 64'(hit), 64'd1);
        for (int p = 0; p < 5; p++) begin
            @(posedge clk); #1;
            in_valid = 1; a_man = $urandom(); b_man = $urandom(); exp_in = $urandom();
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            in_valid = 0;
        end
        force_hold = 0;
        drain();
        repeat (30) @(negedge clk);

        // Randomised traffic.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom(); b = $urandom(); e = $urandom(); end
                1: begin a = $urandom(); b = a; e = $urandom(); end
                2: begin a = $urandom(); b = a + 24'($urandom_range(0, 64)); e = $urandom(); end
                default: begin
                    a = 24'($urandom_range(0, 255)); b = 24'($urandom_range(0, 255));
                    e = 8'($urandom_range(0, 15));
                end
            endcase
            send(a, b, e);
            if ($urandom_range(0, 1) == 0) drain();
        end
        drain();

        // Reset in the middle of a long normalisation.
        send(24'h000001, 24'h000000, 8'h40);
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        q.delete();
        @(negedge clk);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_results", 64'({res_man, res_exp, res_sign, res_zero, res_denorm}), 64'd0);
        check("midreset_in_ready_after", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        check("no_stale_output", 64'({out_valid, in_ready}), 64'b01);

        // Unit still works after the abandoned operation.
        send(24'h800000, 24'h400000, 8'h80); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
